// File: rtl/perceptron_train_seq.sv
// Training sequencer for a single perceptron datapath: holds a host-loaded
// sample memory, replays it epoch by epoch, counts misclassifications and
// reports convergence or epoch-limit exhaustion back to the host.
`timescale 1ns/1ps
module perceptron_train_seq #(
  parameter int ADDR_W     = 3,
  parameter int LAT        = 2,
  parameter int MAX_EPOCHS = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [7:0]        thresh_in,
  input  logic              start,
  input  logic              abort,
  output logic [6:0]        p_in,
  output logic [7:0]        p_threshold,
  output logic              p_exp_res,
  output logic              p_en,
  input  logic [1:0]        p_result,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [3:0]        epoch_cnt,
  output logic [ADDR_W:0]   err_cnt
);

  localparam int              N_SAMPLES = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   ERR_SAT   = (ADDR_W + 1)'(N_SAMPLES);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_SAMPLES - 1);
  localparam logic [3:0]        LAT_L     = 4'(LAT);
  localparam logic [3:0]        MAX_L     = 4'(MAX_EPOCHS);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    EPOCH_END,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [7:0]        mem [N_SAMPLES];
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   run_err;
  logic [3:0]        wait_cnt;
  logic              accept;
  logic              sample_err;
  logic              epoch_clean;
  logic              epoch_limit;
  logic              show_sample;

  // Decode the run-acceptance, per-sample error and end-of-epoch conditions
  always_comb begin
    accept      = (state == IDLE) && start && !abort;
    sample_err  = !((p_result == 2'b01) || (p_result == 2'b11)) ||
                  ((p_result == 2'b01) != mem[idx][7]);
    epoch_clean = (run_err == '0);
    epoch_limit = ((epoch_cnt + 4'd1) == MAX_L);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    next_state  = state;
    show_sample = (state == ISSUE) || (state == WAIT) ||
                  (state == CHECK) || (state == EPOCH_END);
    p_en        = (state == ISSUE);
    busy        = (state != IDLE);
    done        = (state == DONE);
    p_in        = show_sample ? mem[idx][6:0] : 7'd0;
    p_exp_res   = show_sample ? mem[idx][7] : 1'b0;
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      if (accept) next_state = ISSUE;
        ISSUE:     next_state = WAIT;
        WAIT:      if (wait_cnt <= 4'd1) next_state = CHECK;
        CHECK:     next_state = (idx == LAST_IDX) ? EPOCH_END : ISSUE;
        EPOCH_END: next_state = (epoch_clean || epoch_limit) ? DONE : ISSUE;
        DONE:      next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Sample memory: host writes land only while the sequencer is idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SAMPLES; i++) mem[i] <= 8'd0;
    end else if (wr_en && (state == IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Run bookkeeping: threshold latch, sample index, latency wait, error and epoch counts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_threshold <= 8'd0;
      idx         <= '0;
      run_err     <= '0;
      wait_cnt    <= 4'd0;
      epoch_cnt   <= 4'd0;
      err_cnt     <= '0;
      converged   <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      converged <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            p_threshold <= thresh_in;
            idx         <= '0;
            run_err     <= '0;
            epoch_cnt   <= 4'd0;
            err_cnt     <= '0;
            converged   <= 1'b0;
          end
        end
        ISSUE: wait_cnt <= LAT_L;
        WAIT:  wait_cnt <= wait_cnt - 4'd1;
        CHECK: begin
          if (sample_err && (run_err != ERR_SAT)) run_err <= run_err + 1'b1;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        EPOCH_END: begin
          epoch_cnt <= epoch_cnt + 4'd1;
          err_cnt   <= run_err;
          if (epoch_clean) begin
            converged <= 1'b1;
          end else if (epoch_limit) begin
            converged <= 1'b0;
          end else begin
            run_err <= '0;
            idx     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_train_seq.sv
// Self-checking bench for perceptron_train_seq: a latency-aware perceptron
// stub answers from a per-run result table, and an epoch-level model predicts
// every cycle of each run.
`timescale 1ns/1ps
module tb_perceptron_train_seq;

  localparam int ADDR_W = 3;
  localparam int N      = 8;
  localparam int LAT    = 2;
  localparam int MAXE   = 15;
  localparam int SLOT   = LAT + 2;
  localparam int EPLEN  = N * SLOT + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  thresh_in;
  logic        start;
  logic        abort;
  logic [6:0]  p_in;
  logic [7:0]  p_threshold;
  logic        p_exp_res;
  logic        p_en;
  logic [1:0]  p_result;
  logic        busy;
  logic        done;
  logic        converged;
  logic [3:0]  epoch_cnt;
  logic [3:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] modelMem [N];
  logic [1:0] resTab [MAXE][N];
  int         modelE;
  int         modelErr [MAXE];
  bit         modelConv;
  logic [7:0] modelThr;

  bit runActive = 0;
  int t = 0;
  int lastT = 0;
  int doneAt = -1;

  int         pcount = 0;
  int         curG = 0;
  int         age = 1000;
  logic [1:0] stubOut = 2'b10;

  perceptron_train_seq #(.ADDR_W(ADDR_W), .LAT(LAT), .MAX_EPOCHS(MAXE)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .thresh_in(thresh_in), .start(start), .abort(abort), .p_in(p_in),
    .p_threshold(p_threshold), .p_exp_res(p_exp_res), .p_en(p_en), .p_result(p_result),
    .busy(busy), .done(done), .converged(converged), .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  assign p_result = stubOut;

  // Perceptron stub: answers invalid (2'b10) until LAT full cycles after the strobe
  always @(negedge clk) begin
    if (p_en) begin
      curG = pcount;
      pcount++;
      age = 0;
    end else if (age < 1000) begin
      age++;
    end
    if (age > LAT && curG < MAXE * N) stubOut = resTab[curG / N][curG % N];
    else stubOut = 2'b10;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (run cycle %0d)", name, act, exp, t);
    end
  endtask

  // Epoch-level reference: count errors per epoch straight from the labelling rule
  task automatic modelRun();
    int cnt;
    bit wrong;
    modelE = 0;
    modelConv = 0;
    for (int e = 0; e < MAXE; e++) begin
      cnt = 0;
      for (int s = 0; s < N; s++) begin
        wrong = !(resTab[e][s] == 2'b01 || resTab[e][s] == 2'b11) ||
                ((resTab[e][s] == 2'b01) != modelMem[s][7]);
        if (wrong && cnt < N) cnt++;
      end
      modelErr[e] = cnt;
      modelE = e + 1;
      if (cnt == 0) begin
        modelConv = 1;
        break;
      end
    end
  endtask

  // Expected outputs at cycle offset tt after the edge that accepted start
  task automatic checkCycle(input int tt);
    int ep, r, s, doneT;
    doneT = modelE * EPLEN;
    ep = tt / EPLEN;
    r  = tt % EPLEN;
    if (tt == doneT + 1) begin
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
      checkOutput("idle_p_en", p_en, 0);
      checkOutput("idle_converged", converged, modelConv);
      checkOutput("idle_epoch_cnt", epoch_cnt, modelE);
      checkOutput("idle_err_cnt", err_cnt, modelErr[modelE - 1]);
    end else begin
      checkOutput("busy", busy, 1);
      checkOutput("p_threshold", p_threshold, modelThr);
      if (tt == doneT) begin
        checkOutput("done", done, 1);
        checkOutput("done_p_en", p_en, 0);
        checkOutput("done_p_in", p_in, 0);
        checkOutput("done_p_exp_res", p_exp_res, 0);
        checkOutput("done_converged", converged, modelConv);
        checkOutput("done_epoch_cnt", epoch_cnt, modelE);
        checkOutput("done_err_cnt", err_cnt, modelErr[modelE - 1]);
      end else begin
        checkOutput("run_done", done, 0);
        checkOutput("run_converged", converged, 0);
        checkOutput("run_epoch_cnt", epoch_cnt, ep);
        checkOutput("run_err_cnt", err_cnt, (ep == 0) ? 0 : modelErr[ep - 1]);
        if (r < N * SLOT) begin
          s = r / SLOT;
          checkOutput("p_en", p_en, (r % SLOT) == 0);
          checkOutput("p_in", p_in, modelMem[s][6:0]);
          checkOutput("p_exp_res", p_exp_res, modelMem[s][7]);
        end else begin
          checkOutput("epoch_end_p_en", p_en, 0);
        end
      end
    end
  endtask

  // Single compare process following the model through each run
  always @(negedge clk) begin
    if (runActive) begin
      if (done) doneAt = t;
      checkCycle(t);
      t++;
      if (t > lastT) runActive = 0;
    end
  end

  task automatic writeSample(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1; wr_addr = 3'(a); wr_data = d;
    modelMem[a] = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  function automatic void fillEcho();
    for (int e = 0; e < MAXE; e++)
      for (int s = 0; s < N; s++)
        resTab[e][s] = modelMem[s][7] ? 2'b01 : 2'b11;
  endfunction

  // Launch a run (optionally with a same-cycle write) and follow it to completion or abort
  task automatic applyStimulus(input logic [7:0] thr, input bit collide, input int cAddr,
                               input logic [7:0] cData, input int abortT);
    int guard;
    @(negedge clk);
    thresh_in = thr;
    start = 1;
    pcount = 0;
    doneAt = -1;
    if (collide) begin
      wr_en = 1; wr_addr = 3'(cAddr); wr_data = cData;
    end
    modelThr = thr;
    modelRun();
    @(posedge clk);
    t = 0;
    lastT = (abortT >= 0) ? abortT : modelE * EPLEN + 1;
    runActive = 1;
    #1;
    start = 0;
    wr_en = 0;
    if (abortT >= 0) begin
      for (int k = 0; k < abortT; k++) begin
        @(posedge clk);
        #1;
        wr_en = (k >= 3 && k < 6);
        wr_addr = 3'd4;
        wr_data = ~modelMem[4];
      end
      wr_en = 0;
      abort = 1;
      @(posedge clk);
      #1;
      abort = 0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_p_en", p_en, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_converged", converged, 0);
      checkOutput("abort_epoch_cnt", epoch_cnt, 0);
      checkOutput("abort_err_cnt", err_cnt, 0);
      runActive = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checkOutput("abort_no_done", done, 0);
        checkOutput("abort_stays_idle", busy, 0);
      end
    end else begin
      guard = 0;
      while (runActive && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (runActive) begin
        runActive = 0;
        checkOutput("run_timeout", 0, 1);
      end
    end
  endtask

  task automatic checkFinal(input int expE, input int expErr, input bit expConv);
    checkOutput("final_epoch_cnt", epoch_cnt, expE);
    checkOutput("final_err_cnt", err_cnt, expErr);
    checkOutput("final_converged", converged, expConv);
    checkOutput("model_epochs", modelE, expE);
  endtask

  initial begin
    int k;
    logic [7:0] d;
    logic [7:0] cd;
    int ca;
    bit col;
    reset = 0; wr_en = 0; wr_addr = 0; wr_data = 0; thresh_in = 8'hA5; start = 0; abort = 0;
    for (int s = 0; s < N; s++) modelMem[s] = 8'd0;
    fillEcho();
    repeat (2) @(negedge clk);
    checkOutput("rst_p_in", p_in, 0);
    checkOutput("rst_p_threshold", p_threshold, 0);
    checkOutput("rst_p_exp_res", p_exp_res, 0);
    checkOutput("rst_p_en", p_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_converged", converged, 0);
    checkOutput("rst_epoch_cnt", epoch_cnt, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    reset = 1;
    repeat (2) @(negedge clk);

    // Echoing perceptron converges in one epoch; done follows the 34th edge counting the accepting one
    for (int s = 0; s < N; s++) writeSample(s, {s[0], 7'($urandom)});
    fillEcho();
    applyStimulus(8'h3C, 0, 0, 8'h00, -1);
    checkFinal(1, 0, 1);
    checkOutput("p_en_pulses", pcount, 8);
    checkOutput("done_edge", doneAt + 1, 34);

    // Always -1 against all +1 labels: epoch limit reached
    for (int s = 0; s < N; s++) writeSample(s, {1'b1, 7'($urandom)});
    for (int e = 0; e < MAXE; e++) for (int s = 0; s < N; s++) resTab[e][s] = 2'b11;
    applyStimulus(8'h11, 0, 0, 8'h00, -1);
    checkFinal(15, 8, 0);

    // Single wrong answer on sample 3 of the first epoch
    for (int s = 0; s < N; s++) writeSample(s, {1'($urandom), 7'($urandom)});
    fillEcho();
    resTab[0][3] = modelMem[3][7] ? 2'b11 : 2'b01;
    applyStimulus(8'h80, 0, 0, 8'h00, -1);
    checkFinal(2, 0, 1);
    checkOutput("model_first_epoch_err", modelErr[0], 1);

    // Invalid code 2'b00 on sample 5 counts as an error
    fillEcho();
    resTab[0][5] = 2'b00;
    applyStimulus(8'h7F, 0, 0, 8'h00, -1);
    checkFinal(2, 0, 1);
    checkOutput("model_invalid_err", modelErr[0], 1);

    // Abort in the first WAIT cycle of sample 4, writes attempted mid-run, then a clean run
    fillEcho();
    applyStimulus(8'h42, 0, 0, 8'h00, 4 * SLOT + 1);
    abort = 1; start = 1;
    @(negedge clk);
    checkOutput("abort_blocks_start", busy, 0);
    abort = 0; start = 0;
    applyStimulus(8'h43, 0, 0, 8'h00, -1);
    checkFinal(1, 0, 1);

    // Randomized runs: random memory, threshold, error bursts and start/write collisions
    for (int run = 0; run < 8; run++) begin
      k = $urandom_range(0, 8);
      for (int w = 0; w < k; w++) begin
        d = 8'($urandom);
        writeSample($urandom_range(0, N - 1), d);
      end
      col = $urandom_range(0, 1);
      ca = $urandom_range(0, N - 1);
      cd = 8'($urandom);
      if (col) modelMem[ca] = cd;
      k = (run == 7) ? MAXE : $urandom_range(0, 4);
      for (int e = 0; e < MAXE; e++)
        for (int s = 0; s < N; s++)
          if (e < k && $urandom_range(0, 2) == 0) resTab[e][s] = 2'($urandom);
          else resTab[e][s] = modelMem[s][7] ? 2'b01 : 2'b11;
      if (run == 7) for (int s = 0; s < N; s++) resTab[MAXE - 1][s] = 2'b10;
      applyStimulus(8'($urandom), col, ca, cd, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
